// File: rtl/stopwatch_ctrl.sv
// stopwatch_ctrl
// Run-control and time-base stage for the stopwatch digit-counter chain.
// The block turns four debounced button levels into the chain's control
// signals. Those signals are a one-cycle count-enable tick at a prescaled
// rate, the count direction, a one-cycle load strobe and a one-cycle clear
// strobe. A countdown that reaches zero stops the chain. Every output is
// driven from a flop.

module stopwatch_ctrl #(
    parameter int TICK_DIV = 1_000_000,
    parameter int CNT_W    = $clog2(TICK_DIV)
) (
    input  logic clk,
    input  logic reset,
    input  logic start_btn,
    input  logic clear_btn,
    input  logic load_btn,
    input  logic mode_up,
    input  logic chain_zero,
    output logic enable,
    output logic up,
    output logic load,
    output logic clr,
    output logic running,
    output logic done
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

    state_t           state_r;
    logic [CNT_W-1:0] cnt_r;

    // Last sample of each button. These reset to 1 so that a button held
    // down across reset release does not look like a fresh press.
    logic start_q_r;
    logic clear_q_r;
    logic load_q_r;

    logic start_edge_s;
    logic clear_edge_s;
    logic load_edge_s;
    logic tick_due_s;
    logic zero_stop_s;

    // Rising-edge detection, the prescaler wrap point and the countdown stop.
    always_comb begin
        start_edge_s = start_btn & ~start_q_r;
        clear_edge_s = clear_btn & ~clear_q_r;
        load_edge_s  = load_btn  & ~load_q_r;
        tick_due_s   = (cnt_r == CNT_LAST);
        zero_stop_s  = ~up & chain_zero;
    end

    // Button sample registers used for edge detection.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            start_q_r <= 1'b1;
            clear_q_r <= 1'b1;
            load_q_r  <= 1'b1;
        end else begin
            start_q_r <= start_btn;
            clear_q_r <= clear_btn;
            load_q_r  <= load_btn;
        end
    end

    // Run-control FSM, prescaler and registered control outputs.
    // Strobes default low each cycle, so each one lasts a single cycle.
    // Edge priority is clear, then start, then load.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= ST_IDLE;
            cnt_r   <= CNT_ZERO;
            enable  <= 1'b0;
            up      <= 1'b1;
            load    <= 1'b0;
            clr     <= 1'b0;
            running <= 1'b0;
            done    <= 1'b0;
        end else begin
            enable <= 1'b0;
            load   <= 1'b0;
            clr    <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    // Direction follows the switch only while idle.
                    up <= mode_up;
                    if (clear_edge_s) begin
                        clr <= 1'b1;
                    end else if (start_edge_s) begin
                        cnt_r <= CNT_ZERO;
                        if (zero_stop_s) begin
                            // A countdown that is already at zero never runs.
                            state_r <= ST_DONE;
                            running <= 1'b0;
                            done    <= 1'b1;
                        end else begin
                            state_r <= ST_RUN;
                            running <= 1'b1;
                            done    <= 1'b0;
                        end
                    end else if (load_edge_s) begin
                        load <= 1'b1;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end

                ST_RUN: begin
                    if (clear_edge_s) begin
                        state_r <= ST_IDLE;
                        running <= 1'b0;
                        clr     <= 1'b1;
                        cnt_r   <= CNT_ZERO;
                    end else if (zero_stop_s) begin
                        // Reaching zero outranks a tick due in the same cycle.
                        state_r <= ST_DONE;
                        running <= 1'b0;
                        done    <= 1'b1;
                    end else if (start_edge_s) begin
                        // The prescaler phase is held so that resume continues it.
                        state_r <= ST_PAUSE;
                        running <= 1'b0;
                    end else if (tick_due_s) begin
                        cnt_r  <= CNT_ZERO;
                        enable <= 1'b1;
                    end else begin
                        cnt_r <= cnt_r + CNT_ONE;
                    end
                end

                ST_PAUSE: begin
                    if (clear_edge_s) begin
                        state_r <= ST_IDLE;
                        clr     <= 1'b1;
                        cnt_r   <= CNT_ZERO;
                    end else if (start_edge_s) begin
                        state_r <= ST_RUN;
                        running <= 1'b1;
                    end else begin
                        state_r <= ST_PAUSE;
                    end
                end

                ST_DONE: begin
                    if (clear_edge_s) begin
                        state_r <= ST_IDLE;
                        done    <= 1'b0;
                        clr     <= 1'b1;
                        cnt_r   <= CNT_ZERO;
                    end else begin
                        state_r <= ST_DONE;
                    end
                end

                default: begin
                    state_r <= ST_IDLE;
                    cnt_r   <= CNT_ZERO;
                    running <= 1'b0;
                    done    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// tb_stopwatch_ctrl
// Self-checking bench for stopwatch_ctrl with TICK_DIV = 4. It has four
// parts: a table of per-cycle vectors, hand-written multi-cycle sequences,
// a randomized run against a behavioural model, and asynchronous resets
// during that run.

module tb_stopwatch_ctrl;

    localparam int TD = 4;

    logic clk = 1'b0;
    logic reset;
    logic start_btn, clear_btn, load_btn, mode_up, chain_zero;
    logic enable, up, load, clr, running, done;

    int checks   = 0;
    int failures = 0;
    int en_seen  = 0;

    stopwatch_ctrl #(.TICK_DIV(TD)) dut (
        .clk        (clk),
        .reset      (reset),
        .start_btn  (start_btn),
        .clear_btn  (clear_btn),
        .load_btn   (load_btn),
        .mode_up    (mode_up),
        .chain_zero (chain_zero),
        .enable     (enable),
        .up         (up),
        .load       (load),
        .clr        (clr),
        .running    (running),
        .done       (done)
    );

    always #5 clk = ~clk;

    // The want field packs the outputs as {enable, up, load, clr, running, done}.
    typedef struct packed {
        logic       st;
        logic       cl;
        logic       ld;
        logic       mu;
        logic       cz;
        logic [5:0] want;
    } vec_t;

    vec_t tbl[$];

    // Behavioural model. The mode values are 0 = idle, 1 = run, 2 = pause
    // and 3 = done. m_n counts the counting edges since the run started.
    // A tick falls on every TD-th counting edge.
    int   m_mode;
    int   m_n;
    logic m_up, m_en, m_ld, m_cr;
    logic m_ps, m_pc, m_pl;

    function automatic logic [5:0] outs();
        return {enable, up, load, clr, running, done};
    endfunction

    function automatic logic [5:0] m_outs();
        return {m_en, m_up, m_ld, m_cr, (m_mode == 1), (m_mode == 3)};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, want);
        end
    endtask

    task automatic model_reset();
        m_mode = 0; m_n = 0; m_up = 1'b1;
        m_en = 1'b0; m_ld = 1'b0; m_cr = 1'b0;
        m_ps = 1'b1; m_pc = 1'b1; m_pl = 1'b1;
    endtask

    // Predict the outputs after the coming clock edge from the present inputs.
    task automatic model_edge();
        logic se, ce, le, old_up;
        se = start_btn & ~m_ps;
        ce = clear_btn & ~m_pc;
        le = load_btn  & ~m_pl;
        m_ps = start_btn; m_pc = clear_btn; m_pl = load_btn;
        m_en = 1'b0; m_ld = 1'b0; m_cr = 1'b0;
        case (m_mode)
            0: begin
                old_up = m_up;
                m_up = mode_up;
                if (ce) m_cr = 1'b1;
                else if (se) begin
                    m_n = 0;
                    m_mode = (!old_up && chain_zero) ? 3 : 1;
                end
                else if (le) m_ld = 1'b1;
            end
            1: begin
                if (ce) begin m_cr = 1'b1; m_mode = 0; end
                else if (!m_up && chain_zero) m_mode = 3;
                else if (se) m_mode = 2;
                else begin
                    m_n++;
                    m_en = (m_n % TD == 0);
                end
            end
            2: begin
                if (ce) begin m_cr = 1'b1; m_mode = 0; end
                else if (se) m_mode = 1;
            end
            default: begin
                if (ce) begin m_cr = 1'b1; m_mode = 0; end
            end
        endcase
    endtask

    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
        if (enable === 1'b1) en_seen++;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic add(input logic st, input logic cl, input logic ld, input logic mu,
                       input logic cz, input logic [5:0] want);
        tbl.push_back('{st, cl, ld, mu, cz, want});
    endtask

    initial begin
        int total;
        reset = 1'b1;
        start_btn = 1'b0; clear_btn = 1'b0; load_btn = 1'b0;
        mode_up = 1'b1; chain_zero = 1'b0;
        model_reset();

        //   st    cl    ld    mu    cz      en up ld cr ru dn
        add(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 6'b010000); // idle
        add(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 6'b011000); // load edge in idle
        add(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 6'b010000); // load held: one-cycle strobe
        add(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 6'b010010); // start: run, cnt=0
        add(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 6'b010010); // start held: no pause
        add(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 6'b010010);
        add(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 6'b010010);
        add(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 6'b110010); // first tick 4 cycles after start
        add(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 6'b010010);
        add(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 6'b010010);
        add(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 6'b010010);
        add(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 6'b010000); // pause at cnt=TD-1: tick dropped
        add(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 6'b010000);
        add(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 6'b010010); // resume
        add(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 6'b110010); // dropped tick on first edge after resume
        add(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 6'b010100); // clear in run
        add(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 6'b000000); // up follows mode_up in idle
        add(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 6'b000001); // down + zero: straight to done
        add(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 6'b000001);
        add(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 6'b000001); // start/load ignored in done
        add(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 6'b000100); // clear from done, up not resampled
        add(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 6'b010000);
        add(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 6'b010100); // clear+start: clear wins
        add(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 6'b010000);
        add(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 6'b010010); // start+load: run, no load
        add(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 6'b010010);
        add(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 6'b010010); // load and mode change in run ignored
        add(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 6'b010010); // zero while counting up: ignored
        add(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 6'b110010);
        add(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 6'b010100);
        add(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 6'b010000);

        // Table-driven vectors
        do_reset();
        chk("reset_outs", outs(), 6'b010000);
        for (int i = 0; i < tbl.size(); i++) begin
            start_btn  = tbl[i].st;
            clear_btn  = tbl[i].cl;
            load_btn   = tbl[i].ld;
            mode_up    = tbl[i].mu;
            chain_zero = tbl[i].cz;
            step();
            chk($sformatf("vec%0d", i), outs(), tbl[i].want);
        end

        // Pause at cnt=2, hold 10 cycles, resume
        start_btn = 1'b0; clear_btn = 1'b0; load_btn = 1'b0;
        mode_up = 1'b1; chain_zero = 1'b0;
        do_reset();
        step();
        start_btn = 1'b1; step();
        en_seen = 0; total = 0;
        start_btn = 1'b0; step(); step(); total += 2;
        start_btn = 1'b1; step(); total += 1;
        chk("pause_running", running, 0);
        start_btn = 1'b0;
        repeat (10) step();
        total += 10;
        chk("pause_no_enable", en_seen, 0);
        chk("pause_still_paused", running, 0);
        start_btn = 1'b1; step(); total += 1;
        chk("resume_running", running, 1);
        chk("resume_en_r0", enable, 0);
        start_btn = 1'b0; step(); total += 1;
        chk("resume_en_r1", enable, 0);
        step(); total += 1;
        chk("resume_en_r2", enable, 1);
        repeat (14) step();
        total += 14;
        chk("pause_total_ticks", en_seen, (total - 12) / TD);

        // Countdown reaching zero
        do_reset();
        mode_up = 1'b0; step();
        chk("cd_up", up, 0);
        load_btn = 1'b1; step();
        chk("cd_load", {load, up, running}, 3'b100);
        load_btn = 1'b0; step();
        chk("cd_load_1cyc", load, 0);
        start_btn = 1'b1; step();
        chk("cd_run", {running, up}, 2'b10);
        start_btn = 1'b0;
        en_seen = 0;
        for (int i = 0; i < 40 && en_seen < 3; i++) step();
        chk("cd_three_ticks", en_seen, 3);
        chain_zero = 1'b1; step();
        chk("cd_done", {done, running, enable}, 3'b100);
        en_seen = 0;
        repeat (8) step();
        chk("cd_no_enable", en_seen, 0);
        start_btn = 1'b1; step();
        chk("cd_start_ignored", {done, running}, 2'b10);
        start_btn = 1'b0; clear_btn = 1'b1; step();
        chk("cd_clr", {clr, done}, 2'b10);
        clear_btn = 1'b0; step();
        chk("cd_clr_1cyc", clr, 0);
        chain_zero = 1'b0;

        // Reset behaviour
        mode_up = 1'b1;
        start_btn = 1'b1;
        do_reset();
        repeat (3) step();
        chk("held_start_no_run", running, 0);
        start_btn = 1'b0; step();
        start_btn = 1'b1; step();
        chk("restart_run", running, 1);
        start_btn = 1'b0; step(); step();
        mode_up = 1'b0;
        reset = 1'b1;
        model_reset();
        #1;
        chk("async_reset_outs", outs(), 6'b010000);
        @(posedge clk);
        #1;
        reset = 1'b0;
        mode_up = 1'b1;
        step();
        chk("post_reset_idle", {running, done, up}, 3'b001);

        // Randomized run against the model
        start_btn = 1'b0; clear_btn = 1'b0; load_btn = 1'b0; chain_zero = 1'b0;
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 29) == 0)  start_btn = ~start_btn;
            if ($urandom_range(0, 149) == 0) clear_btn = ~clear_btn;
            if ($urandom_range(0, 29) == 0)  load_btn  = ~load_btn;
            if ($urandom_range(0, 199) == 0) mode_up   = ~mode_up;
            chain_zero = ($urandom_range(0, 49) == 0);
            if (i % 700 == 350) begin
                reset = 1'b1;
                model_reset();
                #1;
                chk("rnd_async_reset", outs(), m_outs());
                @(posedge clk);
                #1;
                reset = 1'b0;
            end
            step();
            chk($sformatf("rnd%0d", i), outs(), m_outs());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
